// File: rtl/npc_pkg.sv
// Shared opcode/funct constants and counter width for the next-PC unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package npc_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;

  localparam logic [5:0] FUNCT_JR  = 6'h08;

  localparam int CNT_W = 16;

endpackage

// File: rtl/npc_counter.sv
// Statistics counter: increments by one on each enabled rising edge, wraps at 2^W.
// Latency: one cycle (count visible after the sampling edge); async clear is immediate.
// Backpressure: none; en is sampled every edge.
// Ports: clk, rst_n (async active-low clear), en (count enable), cnt (current count).
module npc_counter
  import npc_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/npc.sv
// Next-PC selection: decodes jump/branch, muxes the next PC and raises a flush on redirect.
// Latency: newpc/pcclear combinational (zero cycles); statistics counters one cycle.
// Backpressure: pcen gates counting only; newpc/pcclear ignore pcen.
// Ports: clk, rst_n, op, pc, aluout, label, rfd1, funct, pcen in;
//        newpc, pcclear, uncondsum, condsuccsum, condsum out.
module npc
  import npc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op,
  input  logic [31:0]       pc,
  input  logic [31:0]       aluout,
  input  logic [25:0]       label,
  input  logic [31:0]       rfd1,
  input  logic [5:0]        funct,
  input  logic              pcen,
  output logic [31:0]       newpc,
  output logic              pcclear,
  output logic [CNT_W-1:0]  uncondsum,
  output logic [CNT_W-1:0]  condsuccsum,
  output logic [CNT_W-1:0]  condsum
);

  logic [31:0] seq;
  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic        uncond;
  logic        cond;
  logic        taken;

  assign seq     = pc + 32'd4;
  assign btarget = seq + {{14{label[15]}}, label[15:0], 2'b00};
  assign jtarget = {pc[31:28], label, 2'b00};

  // A case statement falls to the default arm for unknown opcodes in
  // simulation, so X/Z opcodes decode as "not a jump or branch" and never
  // enable a counter.
  always_comb begin
    uncond = 1'b0;
    cond   = 1'b0;
    taken  = 1'b0;
    newpc  = seq;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          uncond = 1'b1;
          newpc  = rfd1;
        end
      end
      OP_J, OP_JAL: begin
        uncond = 1'b1;
        newpc  = jtarget;
      end
      OP_BEQ: begin
        cond  = 1'b1;
        taken = (aluout == 32'd0);
      end
      OP_BNE: begin
        cond  = 1'b1;
        taken = (aluout != 32'd0);
      end
      OP_REGIMM: begin
        cond  = 1'b1;
        taken = aluout[0];
      end
      default: ;
    endcase
    if (cond && taken) begin
      newpc = btarget;
    end
  end

  assign pcclear = uncond | (cond & taken);

  npc_counter #(.W(CNT_W)) u_uncond (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pcen & uncond),
    .cnt   (uncondsum)
  );

  npc_counter #(.W(CNT_W)) u_cond (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pcen & cond),
    .cnt   (condsum)
  );

  npc_counter #(.W(CNT_W)) u_condsucc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pcen & cond & taken),
    .cnt   (condsuccsum)
  );

endmodule

// File: tb/tb_npc.sv
// Testbench for npc: directed vectors, expectations queued at issue, compared by a monitor.
// Latency: checks combinational outputs mid-cycle and counters one edge after each count.
// Backpressure: n/a.
module tb_npc;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [25:0] label;
  logic [31:0] rfd1;
  logic [5:0]  funct;
  logic        pcen;
  logic [31:0] newpc;
  logic        pcclear;
  logic [15:0] uncondsum;
  logic [15:0] condsuccsum;
  logic [15:0] condsum;

  npc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .pc          (pc),
    .aluout      (aluout),
    .label       (label),
    .rfd1        (rfd1),
    .funct       (funct),
    .pcen        (pcen),
    .newpc       (newpc),
    .pcclear     (pcclear),
    .uncondsum   (uncondsum),
    .condsuccsum (condsuccsum),
    .condsum     (condsum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    logic [31:0] npc;
    logic        clr;
    logic [15:0] u;
    logic [15:0] s;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference counters, advanced by hand-specified kind flags per vector.
  logic [15:0] mu, mc, ms;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle whenever
  // an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.nm, "newpc",       newpc,               e.npc);
      cmp(e.nm, "pcclear",     {31'd0, pcclear},    {31'd0, e.clr});
      cmp(e.nm, "uncondsum",   {16'd0, uncondsum},  {16'd0, e.u});
      cmp(e.nm, "condsuccsum", {16'd0, condsuccsum},{16'd0, e.s});
      cmp(e.nm, "condsum",     {16'd0, condsum},    {16'd0, e.c});
    end
  end

  // Drive one instruction for one cycle (called just after a rising edge).
  task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic [31:0] p, input logic [25:0] l, input logic [31:0] a,
                       input logic [31:0] r, input logic en,
                       input logic [31:0] enpc, input logic eclr,
                       input logic ku, input logic kc, input logic ks, input bit chk);
    op = o; funct = f; pc = p; label = l; aluout = a; rfd1 = r; pcen = en;
    if (chk) exp_q.push_back('{nm, enpc, eclr, mu, ms, mc});
    @(posedge clk);
    if (en && rst_n) begin
      if (ku) mu = mu + 16'd1;
      if (kc) mc = mc + 16'd1;
      if (ks) ms = ms + 16'd1;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    op = 6'h3f; funct = '0; pc = '0; label = '0; aluout = '0; rfd1 = '0; pcen = 1'b0;
    mu = '0; mc = '0; ms = '0;
    @(posedge clk); #1;

    // 1: reset state and JR; counting blocked while reset held
    issue("rst_jr", 6'h00, 6'h08, 32'h0, 26'h0, 32'h0, 32'h00400120, 1'b1, 32'h00400120, 1'b1, 1,0,0, 1);
    rst_n = 1'b1;
    issue("jr",     6'h00, 6'h08, 32'h0, 26'h0, 32'h0, 32'h00400120, 1'b1, 32'h00400120, 1'b1, 1,0,0, 1);
    // 2: J / JAL
    issue("j",   6'h02, 6'h00, 32'hA0001000, 26'h0000040, 32'h0, 32'h0, 1'b1, 32'hA0000100, 1'b1, 1,0,0, 1);
    issue("jal", 6'h03, 6'h00, 32'hA0001000, 26'h0000040, 32'h0, 32'h0, 1'b1, 32'hA0000100, 1'b1, 1,0,0, 1);
    // 3: BEQ taken backwards to self, then not taken
    issue("beq_t",  6'h04, 6'h00, 32'h00001000, 26'h000FFFF, 32'h0, 32'h0, 1'b1, 32'h00001000, 1'b1, 0,1,1, 1);
    issue("beq_nt", 6'h04, 6'h00, 32'h00001000, 26'h000FFFF, 32'h2, 32'h0, 1'b1, 32'h00001004, 1'b0, 0,1,0, 1);
    // 4: BNE and REGIMM
    issue("bne_t",  6'h05, 6'h00, 32'h00001000, 26'h0000010, 32'h2, 32'h0, 1'b1, 32'h00001044, 1'b1, 0,1,1, 1);
    issue("bne_nt", 6'h05, 6'h00, 32'h00001000, 26'h0000010, 32'h0, 32'h0, 1'b1, 32'h00001004, 1'b0, 0,1,0, 1);
    issue("rim_t",  6'h01, 6'h00, 32'h00002000, 26'h0008000, 32'h1, 32'h0, 1'b1, 32'hFFFE2004, 1'b1, 0,1,1, 1);
    issue("rim_nt", 6'h01, 6'h00, 32'h00002000, 26'h0008000, 32'h0, 32'h0, 1'b1, 32'h00002004, 1'b0, 0,1,0, 1);
    // 5: non-branches, PC wrap, pcen low hold
    issue("lw",      6'h23, 6'h00, 32'h00003000, 26'h3FFFFFF, 32'h0, 32'h0, 1'b1, 32'h00003004, 1'b0, 0,0,0, 1);
    issue("add",     6'h00, 6'h20, 32'h00003000, 26'h0, 32'h0, 32'h12345678, 1'b1, 32'h00003004, 1'b0, 0,0,0, 1);
    issue("pc_wrap", 6'h23, 6'h00, 32'hFFFFFFFC, 26'h0, 32'h0, 32'h0, 1'b1, 32'h00000000, 1'b0, 0,0,0, 1);
    for (int i = 0; i < 3; i++)
      issue("hold", 6'h04, 6'h00, 32'h00001000, 26'h000FFFF, 32'h0, 32'h0, 1'b0, 32'h00001000, 1'b1, 0,1,1, 1);
    issue("xop", 6'hxx, 6'hxx, 32'h00004000, 26'h0, 32'h0, 32'h0, 1'b1, 32'h00004004, 1'b0, 0,0,0, 1);
    issue("jr_twice", 6'h00, 6'h08, 32'h0, 26'h0, 32'h0, 32'h00000040, 1'b1, 32'h00000040, 1'b1, 1,0,0, 1);
    issue("jr_twice", 6'h00, 6'h08, 32'h0, 26'h0, 32'h0, 32'h00000040, 1'b1, 32'h00000040, 1'b1, 1,0,0, 1);

    // 6: reset, then 65536 taken BEQs wrap condsum/condsuccsum back to zero
    rst_n = 1'b0; mu = '0; mc = '0; ms = '0;
    issue("wrap_rst", 6'h23, 6'h00, 32'h0, 26'h0, 32'h0, 32'h0, 1'b1, 32'h00000004, 1'b0, 0,0,0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++)
      issue("wrap", 6'h04, 6'h00, 32'h00001000, 26'h000FFFF, 32'h0, 32'h0, 1'b1, 32'h00001000, 1'b1,
            0,1,1, (i == 0 || i == 65535));
    issue("wrap_done", 6'h02, 6'h00, 32'hA0001000, 26'h0000040, 32'h0, 32'h0, 1'b1, 32'hA0000100, 1'b1, 1,0,0, 1);
    issue("pre_rst",   6'h04, 6'h00, 32'h00001000, 26'h000FFFF, 32'h0, 32'h0, 1'b1, 32'h00001000, 1'b1, 0,1,1, 1);

    // Mid-operation reset: counters read zero before the next edge, and an
    // edge while reset is held does not count.
    rst_n = 1'b0; mu = '0; mc = '0; ms = '0;
    issue("mid_rst", 6'h04, 6'h00, 32'h00001000, 26'h000FFFF, 32'h0, 32'h0, 1'b1, 32'h00001000, 1'b1, 0,1,1, 1);
    rst_n = 1'b1;
    issue("after_rst", 6'h02, 6'h00, 32'hA0001000, 26'h0000040, 32'h0, 32'h0, 1'b1, 32'hA0000100, 1'b1, 1,0,0, 1);
    issue("final", 6'h23, 6'h00, 32'h00000010, 26'h0, 32'h0, 32'h0, 1'b0, 32'h00000014, 1'b0, 0,0,0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
